// File: rtl/icache_rsp_pkg.sv
// Shared constants and types for the icache request responder.
// Holds the default parameter values, the address/tag/data typedefs built
// from them, and the width of the outstanding-request counter.
package icache_rsp_pkg;

    localparam int WORD_SIZE_DEF  = 4;
    localparam int ADDR_WIDTH_DEF = 30;
    localparam int TAG_WIDTH_DEF  = 8;
    localparam int DEPTH_DEF      = 4;
    localparam int DATA_WIDTH_DEF = WORD_SIZE_DEF * 8;

    localparam int PENDING_W = $clog2(DEPTH_DEF + 1);

    typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
    typedef logic [TAG_WIDTH_DEF-1:0]  tag_t;
    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/icache_rsp_fifo.sv
// Synchronous FIFO used for both the tag queue and the read-data queue.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, data_i    write strobe and write data
//   pop_i             read strobe (advances head)
//   head_o            oldest entry (valid when !empty_o)
//   empty_o, full_o   occupancy flags
//   count_o           current occupancy
// A push while full is accepted only when a pop happens in the same cycle.
// Storage is cleared by reset so the head reads as zero afterwards.
module icache_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_DEPTH);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/icache_req_responder.sv
// Slave endpoint of the icache request interface. Requests pass straight
// through to the memory read port; in-order read data is queued, paired
// with the queued request tag and returned on the response channel.
// A credit counter bounds outstanding reads to DEPTH.
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   icache_req_valid/addr/tag/ready    fetch request channel (slave)
//   mem_req_valid/addr/ready           memory read request (master)
//   mem_rsp_valid/data                 in-order read data, no backpressure
//   icache_rsp_valid/data/tag/ready    response channel (master)
//   perf_stall_cycles, perf_req_count  only with ICACHE_RSP_PERF_EN defined
// Optional feature macro: ICACHE_RSP_PERF_EN.
module icache_req_responder
    import icache_rsp_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   icache_req_valid,
    input  logic [ADDR_WIDTH-1:0]  icache_req_addr,
    input  logic [TAG_WIDTH-1:0]   icache_req_tag,
    output logic                   icache_req_ready,
    output logic                   mem_req_valid,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_rsp_valid,
    input  logic [WORD_SIZE*8-1:0] mem_rsp_data,
    output logic                   icache_rsp_valid,
    output logic [WORD_SIZE*8-1:0] icache_rsp_data,
    output logic [TAG_WIDTH-1:0]   icache_rsp_tag,
    input  logic                   icache_rsp_ready
`ifdef ICACHE_RSP_PERF_EN
    ,
    output logic [31:0]            perf_stall_cycles,
    output logic [31:0]            perf_req_count
`endif
);

    localparam int DATA_W = WORD_SIZE * 8;
    localparam int PEND_W = $clog2(DEPTH + 1);
    localparam logic [PEND_W-1:0] PEND_DEPTH = PEND_W'(DEPTH);
    localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);

    logic [PEND_W-1:0] pending_q;
    logic [PEND_W-1:0] pending_d;
    logic [PEND_W-1:0] tag_count;
    logic [PEND_W-1:0] data_count;
    logic              has_credit;
    logic              req_fire;
    logic              rsp_fire;
    logic              tag_waiting;
    logic              data_push;
    logic              tag_empty;
    logic              tag_full;
    logic              data_empty;
    logic              data_full;

    assign has_credit = (pending_q < PEND_DEPTH);

    // Gating with reset makes the request handshake drop the instant reset
    // asserts, rather than waiting for a clock edge.
    assign icache_req_ready = reset && mem_req_ready && has_credit;
    assign mem_req_valid    = reset && icache_req_valid && has_credit;
    assign mem_req_addr     = icache_req_addr;
    assign req_fire         = icache_req_valid && icache_req_ready;

    assign icache_rsp_valid = !data_empty;
    assign rsp_fire         = icache_rsp_valid && icache_rsp_ready;

    // Read data is only legal for a tag still awaiting its data; this also
    // excludes a full data queue, since data never outnumbers tags.
    assign tag_waiting = (tag_count > data_count);
    assign data_push   = mem_rsp_valid && tag_waiting;

    always_comb begin
        pending_d = pending_q;
        case ({req_fire, rsp_fire})
            2'b10:   pending_d = pending_q + PEND_ONE;
            2'b01:   pending_d = pending_q - PEND_ONE;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    icache_rsp_fifo #(
        .WIDTH (TAG_WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (req_fire),
        .data_i  (icache_req_tag),
        .pop_i   (rsp_fire),
        .head_o  (icache_rsp_tag),
        .empty_o (tag_empty),
        .full_o  (tag_full),
        .count_o (tag_count)
    );

    icache_rsp_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (data_push),
        .data_i  (mem_rsp_data),
        .pop_i   (rsp_fire),
        .head_o  (icache_rsp_data),
        .empty_o (data_empty),
        .full_o  (data_full),
        .count_o (data_count)
    );

`ifdef ICACHE_RSP_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_req_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_req_q   <= '0;
        end else begin
            if (icache_req_valid && !icache_req_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (req_fire) begin
                perf_req_q <= perf_req_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_req_count    = perf_req_q;
`endif

`ifndef SYNTHESIS
    // Read data with no tag awaiting it (or a full data queue) is dropped.
    a_rsp_has_slot: assert property (@(posedge clk) disable iff (!reset)
        mem_rsp_valid |-> (tag_waiting && !data_full));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        req_fire |-> !tag_full);
    a_pop_has_tag: assert property (@(posedge clk) disable iff (!reset)
        rsp_fire |-> !tag_empty);
`endif

endmodule

// File: tb/tb_icache_req_responder.sv
module tb_icache_req_responder;
    import icache_rsp_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  icache_req_valid;
    addr_t icache_req_addr;
    tag_t  icache_req_tag;
    logic  icache_req_ready;
    logic  mem_req_valid;
    addr_t mem_req_addr;
    logic  mem_req_ready;
    logic  mem_rsp_valid;
    data_t mem_rsp_data;
    logic  icache_rsp_valid;
    data_t icache_rsp_data;
    tag_t  icache_rsp_tag;
    logic  icache_rsp_ready;
`ifdef ICACHE_RSP_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_req_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    icache_req_responder dut (
        .clk              (clk),
        .reset            (reset),
        .icache_req_valid (icache_req_valid),
        .icache_req_addr  (icache_req_addr),
        .icache_req_tag   (icache_req_tag),
        .icache_req_ready (icache_req_ready),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_ready    (mem_req_ready),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_data     (mem_rsp_data),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_data  (icache_rsp_data),
        .icache_rsp_tag   (icache_rsp_tag),
        .icache_rsp_ready (icache_rsp_ready)
`ifdef ICACHE_RSP_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_req_count    (perf_req_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        icache_req_valid = 1'b1;
        icache_req_addr  = 30'h5;
        icache_req_tag   = 8'h5;
        mem_req_ready    = 1'b1;
        mem_rsp_valid    = 1'b0;
        mem_rsp_data     = '0;
        icache_rsp_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (icache_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req_ready got %0h exp 0", icache_req_ready);
        end
        n_cmp++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mem_req_valid got %0h exp 0", mem_req_valid);
        end
        n_cmp++;
        if (icache_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rsp_valid got %0h exp 0", icache_rsp_valid);
        end
        icache_req_valid = 1'b0;
        reset            = 1'b1;
        tick();
        n_cmp++;
        if ({icache_rsp_data, icache_rsp_tag} !== 40'h0) begin
            n_fail++;
            $display("FAIL rst_rsp_data_tag got %h_%h exp 0_0", icache_rsp_data, icache_rsp_tag);
        end
        n_cmp++;
        if (icache_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready got %0h exp 1", icache_req_ready);
        end
    endtask

    task automatic test_single();
        icache_req_valid = 1'b1;
        icache_req_addr  = 30'h10;
        icache_req_tag   = 8'h3A;
        #1;
        n_cmp++;
        if ({mem_req_valid, icache_req_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL single_req_handshake got %b exp 11", {mem_req_valid, icache_req_ready});
        end
        n_cmp++;
        if (mem_req_addr !== 30'h10) begin
            n_fail++;
            $display("FAIL single_mem_addr got %h exp 10", mem_req_addr);
        end
        tick();
        icache_req_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (icache_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp_early got %0h exp 0", icache_rsp_valid);
        end
        tick();
        mem_rsp_valid = 1'b0;
        n_cmp++;
        if ({icache_rsp_valid, icache_rsp_data, icache_rsp_tag} !== {1'b1, 32'hDEADBEEF, 8'h3A}) begin
            n_fail++;
            $display("FAIL single_rsp got v=%0h d=%h t=%h exp v=1 d=deadbeef t=3a",
                     icache_rsp_valid, icache_rsp_data, icache_rsp_tag);
        end
        n_cmp++;
        if (dut.pending_q !== 3'd1) begin
            n_fail++;
            $display("FAIL single_pending got %0d exp 1", dut.pending_q);
        end
        icache_rsp_ready = 1'b1;
        tick();
        icache_rsp_ready = 1'b0;
        n_cmp++;
        if ({icache_rsp_valid, dut.pending_q} !== 4'b0_000) begin
            n_fail++;
            $display("FAIL single_drain got v=%0h p=%0d exp v=0 p=0", icache_rsp_valid, dut.pending_q);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            icache_req_valid = 1'b1;
            icache_req_addr  = 30'h100 + 30'(i);
            icache_req_tag   = 8'(i);
            #1;
            n_cmp++;
            if (icache_req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_accept_%0d got %0h exp 1", i, icache_req_ready);
            end
            tick();
        end
        icache_req_addr = 30'h105;
        icache_req_tag  = 8'd5;
        #1;
        n_cmp++;
        if ({icache_req_ready, mem_req_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_full_block got %b exp 00", {icache_req_ready, mem_req_valid});
        end
        n_cmp++;
        if (dut.pending_q !== 3'd4) begin
            n_fail++;
            $display("FAIL b2b_pending_full got %0d exp 4", dut.pending_q);
        end
        for (int i = 1; i <= 4; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hA000_0000 + 32'(i);
            tick();
        end
        mem_rsp_valid    = 1'b0;
        icache_rsp_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_cmp++;
            if ({icache_rsp_valid, icache_rsp_tag, icache_rsp_data} !==
                {1'b1, 8'(i), 32'hA000_0000 + 32'(i)}) begin
                n_fail++;
                $display("FAIL b2b_rsp_%0d got v=%0h t=%h d=%h exp v=1 t=%h d=%h", i,
                         icache_rsp_valid, icache_rsp_tag, icache_rsp_data, 8'(i),
                         32'hA000_0000 + 32'(i));
            end
            // Full on the first pop cycle: no ready-through from the response side.
            n_cmp++;
            if (icache_req_ready !== (i != 1)) begin
                n_fail++;
                $display("FAIL b2b_req_ready_%0d got %0h exp %0h", i, icache_req_ready, (i != 1));
            end
            tick();
            if (i == 2) icache_req_valid = 1'b0;
        end
        icache_rsp_ready = 1'b0;
        n_cmp++;
        if ({icache_rsp_valid, dut.pending_q} !== 4'b0_001) begin
            n_fail++;
            $display("FAIL b2b_after_drain got v=%0h p=%0d exp v=0 p=1", icache_rsp_valid, dut.pending_q);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0055;
        tick();
        mem_rsp_valid = 1'b0;
        n_cmp++;
        if ({icache_rsp_valid, icache_rsp_tag, icache_rsp_data} !== {1'b1, 8'd5, 32'h55}) begin
            n_fail++;
            $display("FAIL b2b_fifth_rsp got v=%0h t=%h d=%h exp v=1 t=05 d=55",
                     icache_rsp_valid, icache_rsp_tag, icache_rsp_data);
        end
        icache_rsp_ready = 1'b1;
        tick();
        icache_rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        icache_req_valid = 1'b1;
        icache_req_addr  = 30'h20;
        icache_req_tag   = 8'h77;
        tick();
        icache_req_valid = 1'b0;
        mem_rsp_valid    = 1'b1;
        mem_rsp_data     = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_cmp++;
            if ({icache_rsp_valid, icache_rsp_data, icache_rsp_tag} !== {1'b1, 32'h1234_5678, 8'h77}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got v=%0h d=%h t=%h exp v=1 d=12345678 t=77", c,
                         icache_rsp_valid, icache_rsp_data, icache_rsp_tag);
            end
            tick();
        end
        icache_rsp_ready = 1'b1;
        tick();
        icache_rsp_ready = 1'b0;
        n_cmp++;
        if ({icache_rsp_valid, dut.pending_q} !== 4'b0_000) begin
            n_fail++;
            $display("FAIL bp_single_pop got v=%0h p=%0d exp v=0 p=0", icache_rsp_valid, dut.pending_q);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 3; i++) begin
            icache_req_valid = 1'b1;
            icache_req_addr  = 30'h300 + 30'(i);
            icache_req_tag   = 8'h30 + 8'(i);
            tick();
        end
        icache_req_valid = 1'b0;
        mem_rsp_valid    = 1'b1;
        mem_rsp_data     = 32'hD1;
        tick();
        mem_rsp_valid    = 1'b0;
        icache_req_valid = 1'b1;
        icache_req_addr  = 30'h304;
        icache_req_tag   = 8'h34;
        icache_rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({icache_req_ready, icache_rsp_valid, icache_rsp_tag} !== {2'b11, 8'h31}) begin
            n_fail++;
            $display("FAIL sim_both_fire got rr=%0h v=%0h t=%h exp rr=1 v=1 t=31",
                     icache_req_ready, icache_rsp_valid, icache_rsp_tag);
        end
        tick();
        icache_req_valid = 1'b0;
        icache_rsp_ready = 1'b0;
        n_cmp++;
        if (dut.pending_q !== 3'd3) begin
            n_fail++;
            $display("FAIL sim_pending got %0d exp 3", dut.pending_q);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hD2;
        tick();
        n_cmp++;
        if ({icache_rsp_valid, icache_rsp_tag, icache_rsp_data} !== {1'b1, 8'h32, 32'hD2}) begin
            n_fail++;
            $display("FAIL sim_next_tag got v=%0h t=%h d=%h exp v=1 t=32 d=d2",
                     icache_rsp_valid, icache_rsp_tag, icache_rsp_data);
        end
        // Push and pop together at occupancy 1.
        icache_rsp_ready = 1'b1;
        mem_rsp_data     = 32'hD3;
        tick();
        n_cmp++;
        if ({icache_rsp_valid, icache_rsp_tag, icache_rsp_data} !== {1'b1, 8'h33, 32'hD3}) begin
            n_fail++;
            $display("FAIL sim_pushpop_1 got v=%0h t=%h d=%h exp v=1 t=33 d=d3",
                     icache_rsp_valid, icache_rsp_tag, icache_rsp_data);
        end
        mem_rsp_data = 32'hD4;
        tick();
        n_cmp++;
        if ({icache_rsp_valid, icache_rsp_tag, icache_rsp_data} !== {1'b1, 8'h34, 32'hD4}) begin
            n_fail++;
            $display("FAIL sim_pushpop_2 got v=%0h t=%h d=%h exp v=1 t=34 d=d4",
                     icache_rsp_valid, icache_rsp_tag, icache_rsp_data);
        end
        mem_rsp_valid = 1'b0;
        tick();
        icache_rsp_ready = 1'b0;
        n_cmp++;
        if ({icache_rsp_valid, dut.pending_q} !== 4'b0_000) begin
            n_fail++;
            $display("FAIL sim_drain got v=%0h p=%0d exp v=0 p=0", icache_rsp_valid, dut.pending_q);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 2; i++) begin
            icache_req_valid = 1'b1;
            icache_req_addr  = 30'h400 + 30'(i);
            icache_req_tag   = 8'h40 + 8'(i);
            tick();
        end
        icache_req_valid = 1'b0;
        mem_rsp_valid    = 1'b1;
        mem_rsp_data     = 32'hCAFE_0001;
        tick();
        mem_rsp_valid    = 1'b0;
        icache_req_valid = 1'b1;
        icache_req_tag   = 8'h43;
        #1;
        n_cmp++;
        if ({icache_rsp_valid, mem_req_valid, dut.pending_q} !== {2'b11, 3'd2}) begin
            n_fail++;
            $display("FAIL arst_pre got v=%0h mv=%0h p=%0d exp v=1 mv=1 p=2",
                     icache_rsp_valid, mem_req_valid, dut.pending_q);
        end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({icache_rsp_valid, mem_req_valid, icache_req_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL arst_drop got %b exp 000",
                     {icache_rsp_valid, mem_req_valid, icache_req_ready});
        end
        n_cmp++;
        if (dut.pending_q !== 3'd0) begin
            n_fail++;
            $display("FAIL arst_pending got %0d exp 0", dut.pending_q);
        end
        icache_req_valid = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({icache_rsp_valid, dut.pending_q, icache_req_ready} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL arst_release got v=%0h p=%0d rr=%0h exp v=0 p=0 rr=1",
                     icache_rsp_valid, dut.pending_q, icache_req_ready);
        end
        mem_req_ready = 1'b0;
        #1;
        n_cmp++;
        if (icache_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_ready_follow got %0h exp 0", icache_req_ready);
        end
        mem_req_ready = 1'b1;
        #1;
    endtask

`ifdef ICACHE_RSP_PERF_EN
    task automatic test_perf();
        mem_req_ready    = 1'b0;
        icache_req_valid = 1'b1;
        icache_req_addr  = 30'h500;
        icache_req_tag   = 8'h50;
        for (int c = 0; c < 5; c++) tick();
        mem_req_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        icache_req_valid = 1'b0;
        #1;
        n_cmp++;
        if (perf_stall_cycles !== 32'd5) begin
            n_fail++;
            $display("FAIL perf_stall got %0d exp 5", perf_stall_cycles);
        end
        n_cmp++;
        if (perf_req_count !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_req got %0d exp 3", perf_req_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_async_reset();
`ifdef ICACHE_RSP_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
